// File: rtl/vlb_reg_master_if.sv
// vlb_reg_master_if: bundles the command, response and VLB request/response
// signals of the VLB register access engine.
//   master modport : the engine (drives cmd_ready, rsp_*, vlb_req/we/addr/wdata)
//   slave modport  : the agent and responder side (drives everything else)
interface vlb_reg_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rnw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              vlb_req;
  logic              vlb_we;
  logic [ADDR_W-1:0] vlb_addr;
  logic [DATA_W-1:0] vlb_wdata;
  logic [DATA_W-1:0] vlb_rdata;
  logic              vlb_ack;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, rsp_ready, vlb_rdata, vlb_ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, vlb_req, vlb_we, vlb_addr, vlb_wdata
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, rsp_ready, vlb_rdata, vlb_ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, vlb_req, vlb_we, vlb_addr, vlb_wdata
  );
endinterface

// File: rtl/vlb_reg_master.sv
// vlb_reg_master: initiator-side VLB register access engine.
// Accepts one read/write command at a time, runs exactly one VLB transaction
// for it (none for a misaligned address) and returns data/status on the
// response port. All bus and response fields come straight from flops;
// cmd_ready and rsp_valid are pure state decodes.
// Optional feature: define VLB_REG_MASTER_TIMEOUT_EN to abort a bus
// transaction that sees no vlb_ack within TIMEOUT_CYCLES BUS cycles.
module vlb_reg_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  vlb_reg_master_if.master  bus
);

  // The counter is 8 bits wide, so the limit must fit and be non-zero.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range
    $error("vlb_reg_master: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              misaligned_s;
  logic              cmd_ready_s;
  logic              rsp_valid_s;
  logic              vlb_req_r;
  logic              vlb_req_nxt_s;
  logic              vlb_we_r;
  logic              vlb_we_nxt_s;
  logic [ADDR_W-1:0] vlb_addr_r;
  logic [ADDR_W-1:0] vlb_addr_nxt_s;
  logic [DATA_W-1:0] vlb_wdata_r;
  logic [DATA_W-1:0] vlb_wdata_nxt_s;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic [DATA_W-1:0] rsp_rdata_nxt_s;
  logic              rsp_err_r;
  logic              rsp_err_nxt_s;

`ifdef VLB_REG_MASTER_TIMEOUT_EN
  // Last BUS cycle index (0-based) that may still complete before aborting.
  localparam logic [7:0] TMO_LAST_C = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_r;
  logic [7:0] tmo_cnt_nxt_s;
  logic       tmo_hit_s;

  // Timeout fires only when no ack arrives in the final allowed BUS cycle.
  assign tmo_hit_s = (state_r == ST_BUS) && !bus.vlb_ack && (tmo_cnt_r == TMO_LAST_C);
`endif

  assign misaligned_s = (bus.cmd_addr[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one bus transaction per command, then hold the response.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt_s = misaligned_s ? ST_RESP : ST_BUS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus.vlb_ack) begin
          state_nxt_s = ST_RESP;
        end
`ifdef VLB_REG_MASTER_TIMEOUT_EN
        else if (tmo_hit_s) begin
          state_nxt_s = ST_RESP;
        end
`endif
        else begin
          state_nxt_s = ST_BUS;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: handshake decodes plus next values of the registered outputs.
  always_comb begin
    cmd_ready_s     = (state_r == ST_IDLE) && !rst;
    rsp_valid_s     = (state_r == ST_RESP);
    vlb_req_nxt_s   = vlb_req_r;
    vlb_we_nxt_s    = vlb_we_r;
    vlb_addr_nxt_s  = vlb_addr_r;
    vlb_wdata_nxt_s = vlb_wdata_r;
    rsp_rdata_nxt_s = rsp_rdata_r;
    rsp_err_nxt_s   = rsp_err_r;
`ifdef VLB_REG_MASTER_TIMEOUT_EN
    tmo_cnt_nxt_s   = tmo_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (misaligned_s) begin
            // Rejected without touching the bus.
            vlb_req_nxt_s   = 1'b0;
            rsp_err_nxt_s   = 1'b1;
            rsp_rdata_nxt_s = {DATA_W{1'b0}};
          end else begin
            vlb_req_nxt_s   = 1'b1;
            vlb_we_nxt_s    = ~bus.cmd_rnw;
            vlb_addr_nxt_s  = bus.cmd_addr;
            vlb_wdata_nxt_s = bus.cmd_wdata;
`ifdef VLB_REG_MASTER_TIMEOUT_EN
            tmo_cnt_nxt_s   = 8'd0;
`endif
          end
        end else begin
          vlb_req_nxt_s = 1'b0;
        end
      end
      ST_BUS: begin
        if (bus.vlb_ack) begin
          // Ack wins over a timeout landing in the same cycle.
          vlb_req_nxt_s   = 1'b0;
          rsp_rdata_nxt_s = vlb_we_r ? {DATA_W{1'b0}} : bus.vlb_rdata;
          rsp_err_nxt_s   = 1'b0;
        end
`ifdef VLB_REG_MASTER_TIMEOUT_EN
        else if (tmo_hit_s) begin
          vlb_req_nxt_s   = 1'b0;
          rsp_rdata_nxt_s = {DATA_W{1'b0}};
          rsp_err_nxt_s   = 1'b1;
        end
`endif
        else begin
          vlb_req_nxt_s = 1'b1;
`ifdef VLB_REG_MASTER_TIMEOUT_EN
          tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
`endif
        end
      end
      ST_RESP: begin
        vlb_req_nxt_s = 1'b0;
      end
      default: begin
        vlb_req_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered bus and response fields; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      vlb_req_r   <= 1'b0;
      vlb_we_r    <= 1'b0;
      vlb_addr_r  <= {ADDR_W{1'b0}};
      vlb_wdata_r <= {DATA_W{1'b0}};
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
`ifdef VLB_REG_MASTER_TIMEOUT_EN
      tmo_cnt_r   <= 8'd0;
`endif
    end else begin
      vlb_req_r   <= vlb_req_nxt_s;
      vlb_we_r    <= vlb_we_nxt_s;
      vlb_addr_r  <= vlb_addr_nxt_s;
      vlb_wdata_r <= vlb_wdata_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
`ifdef VLB_REG_MASTER_TIMEOUT_EN
      tmo_cnt_r   <= tmo_cnt_nxt_s;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.vlb_req   = vlb_req_r;
  assign bus.vlb_we    = vlb_we_r;
  assign bus.vlb_addr  = vlb_addr_r;
  assign bus.vlb_wdata = vlb_wdata_r;

endmodule

// File: tb/tb_vlb_reg_master.sv
// Directed testbench for vlb_reg_master with a small behavioural VLB
// register responder (0x4 volatile = 0x2C, 0x8 data, 0xC control).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vlb_reg_master;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vlb_reg_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  vlb_reg_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Responder configuration and register contents.
  int          ack_delay = 0;
  bit          ack_never = 1'b0;
  bit          ack_force = 1'b0;
  int          resp_k    = 0;
  logic [31:0] data_reg  = 32'h0000_0000;
  logic [31:0] ctrl_reg  = 32'hA5A5_0001;

  // Responder: acks in BUS cycle ack_delay+1 with combinational-style timing.
  always @(negedge clk) begin
    if (bus_if.vlb_req === 1'b1) begin
      resp_k = resp_k + 1;
      if (!ack_never && (resp_k == ack_delay + 1)) begin
        bus_if.vlb_ack = 1'b1;
        if (bus_if.vlb_we === 1'b1) begin
          if (bus_if.vlb_addr == 32'h0000_0008) data_reg = bus_if.vlb_wdata;
          if (bus_if.vlb_addr == 32'h0000_000C) ctrl_reg = bus_if.vlb_wdata;
          bus_if.vlb_rdata = 32'h0000_0000;
        end else begin
          case (bus_if.vlb_addr)
            32'h0000_0004: bus_if.vlb_rdata = 32'h0000_002C;
            32'h0000_0008: bus_if.vlb_rdata = data_reg;
            32'h0000_000C: bus_if.vlb_rdata = ctrl_reg;
            default:       bus_if.vlb_rdata = 32'h0000_0000;
          endcase
        end
      end else begin
        bus_if.vlb_ack   = 1'b0;
        bus_if.vlb_rdata = 32'hFFFF_FFFF;
      end
    end else begin
      resp_k           = 0;
      bus_if.vlb_ack   = ack_force;
      bus_if.vlb_rdata = 32'hFFFF_FFFF;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Present one command for a single cycle (caller is at a falling edge, DUT idle).
  task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_rnw   = rnw;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wdata;
    step();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while ((bus_if.rsp_valid !== 1'b1) && (n < 200)) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    bus_if.rsp_ready = 1'b1;
    step();
    bus_if.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({bus_if.cmd_ready, bus_if.rsp_valid, bus_if.vlb_req, bus_if.vlb_we, bus_if.rsp_err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {bus_if.cmd_ready, bus_if.rsp_valid, bus_if.vlb_req, bus_if.vlb_we, bus_if.rsp_err});
    end
    checks++;
    if ({bus_if.vlb_addr, bus_if.vlb_wdata, bus_if.rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h required zeros",
               bus_if.vlb_addr, bus_if.vlb_wdata, bus_if.rsp_rdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: got %b required 1", bus_if.cmd_ready);
    end
  endtask

  task automatic test_read_volatile();
    issue(1'b1, 32'h0000_0004, 32'h0000_0000);
    checks++;
    if ({bus_if.vlb_req, bus_if.vlb_we, bus_if.cmd_ready, bus_if.rsp_valid} !== 4'b1000 ||
        bus_if.vlb_addr !== 32'h0000_0004) begin
      errors++;
      $display("FAIL rd4_bus: got req/we/rdy/rv=%b addr=%h required 1000 addr=00000004",
               {bus_if.vlb_req, bus_if.vlb_we, bus_if.cmd_ready, bus_if.rsp_valid}, bus_if.vlb_addr);
    end
    step();
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.vlb_req} !== 3'b100 ||
        bus_if.rsp_rdata !== 32'h0000_002C) begin
      errors++;
      $display("FAIL rd4_rsp: got rv/err/req=%b rdata=%h required 100 rdata=0000002c",
               {bus_if.rsp_valid, bus_if.rsp_err, bus_if.vlb_req}, bus_if.rsp_rdata);
    end
    handshake();
    checks++;
    if ({bus_if.rsp_valid, bus_if.cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd4_done: got rv/rdy=%b required 01", {bus_if.rsp_valid, bus_if.cmd_ready});
    end
  endtask

  task automatic test_write_read();
    issue(1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
    checks++;
    if ({bus_if.vlb_req, bus_if.vlb_we} !== 2'b11 || bus_if.vlb_addr !== 32'h0000_0008 ||
        bus_if.vlb_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr8_bus: got req/we=%b addr=%h wdata=%h required 11 00000008 deadbeef",
               {bus_if.vlb_req, bus_if.vlb_we}, bus_if.vlb_addr, bus_if.vlb_wdata);
    end
    wait_rsp();
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_err} !== 2'b10 || bus_if.rsp_rdata !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wr8_rsp: got rv/err=%b rdata=%h required 10 00000000",
               {bus_if.rsp_valid, bus_if.rsp_err}, bus_if.rsp_rdata);
    end
    handshake();
    issue(1'b1, 32'h0000_0008, 32'h0000_0000);
    wait_rsp();
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_err} !== 2'b10 || bus_if.rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd8_rsp: got rv/err=%b rdata=%h required 10 deadbeef",
               {bus_if.rsp_valid, bus_if.rsp_err}, bus_if.rsp_rdata);
    end
    handshake();
  endtask

  task automatic test_misaligned();
    issue(1'b1, 32'h0000_000E, 32'h0000_0000);
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.vlb_req} !== 3'b110 ||
        bus_if.rsp_rdata !== 32'h0000_0000) begin
      errors++;
      $display("FAIL misaligned: got rv/err/req=%b rdata=%h required 110 00000000",
               {bus_if.rsp_valid, bus_if.rsp_err, bus_if.vlb_req}, bus_if.rsp_rdata);
    end
    handshake();
  endtask

  task automatic test_stall();
    ack_delay = 5;
    issue(1'b1, 32'h0000_0008, 32'h0BAD_F00D);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bus_if.vlb_req, bus_if.vlb_we, bus_if.cmd_ready, bus_if.rsp_valid} !== 4'b1000 ||
          bus_if.vlb_addr !== 32'h0000_0008 || bus_if.vlb_wdata !== 32'h0BAD_F00D) begin
        errors++;
        $display("FAIL stall_bus[%0d]: got req/we/rdy/rv=%b addr=%h wdata=%h required 1000 00000008 0badf00d",
                 k, {bus_if.vlb_req, bus_if.vlb_we, bus_if.cmd_ready, bus_if.rsp_valid},
                 bus_if.vlb_addr, bus_if.vlb_wdata);
      end
      step();
    end
    ack_delay = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.cmd_ready, bus_if.vlb_req} !== 4'b1000 ||
          bus_if.rsp_rdata !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL stall_rsp[%0d]: got rv/err/rdy/req=%b rdata=%h required 1000 deadbeef",
                 k, {bus_if.rsp_valid, bus_if.rsp_err, bus_if.cmd_ready, bus_if.vlb_req},
                 bus_if.rsp_rdata);
      end
      step();
    end
    handshake();
    checks++;
    if ({bus_if.rsp_valid, bus_if.cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_done: got rv/rdy=%b required 01", {bus_if.rsp_valid, bus_if.cmd_ready});
    end
  endtask

  task automatic test_spurious_ack();
    ack_force = 1'b1;
    step();
    step();
    checks++;
    if ({bus_if.rsp_valid, bus_if.cmd_ready, bus_if.vlb_req} !== 3'b010) begin
      errors++;
      $display("FAIL spurious_ack: got rv/rdy/req=%b required 010",
               {bus_if.rsp_valid, bus_if.cmd_ready, bus_if.vlb_req});
    end
    ack_force = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int n_rsp = 0;
    int n_req = 0;
    int n_rdy = 0;
    int n_ovl = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_rnw   = 1'b1;
    bus_if.cmd_addr  = 32'h0000_0004;
    bus_if.cmd_wdata = 32'h0000_0000;
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus_if.rsp_valid === 1'b1) n_rsp++;
      if (bus_if.vlb_req === 1'b1) n_req++;
      if (bus_if.cmd_ready === 1'b1) n_rdy++;
      if ((bus_if.rsp_valid === 1'b1) && (bus_if.cmd_ready === 1'b1)) n_ovl++;
    end
    bus_if.cmd_valid = 1'b0;
    bus_if.rsp_ready = 1'b0;
    checks++;
    if (n_rsp != 3 || n_req != 3 || n_rdy != 3 || n_ovl != 0) begin
      errors++;
      $display("FAIL back_to_back: got rsp=%0d req=%0d rdy=%0d overlap=%0d required 3 3 3 0",
               n_rsp, n_req, n_rdy, n_ovl);
    end
    checks++;
    if (bus_if.rsp_rdata !== 32'h0000_002C) begin
      errors++;
      $display("FAIL back_to_back_data: got %h required 0000002c", bus_if.rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    ack_never = 1'b1;
    issue(1'b0, 32'h0000_000C, 32'h0000_0055);
    checks++;
    if ({bus_if.vlb_req, bus_if.vlb_we} !== 2'b11 || bus_if.vlb_addr !== 32'h0000_000C) begin
      errors++;
      $display("FAIL rstmid_bus: got req/we=%b addr=%h required 11 0000000c",
               {bus_if.vlb_req, bus_if.vlb_we}, bus_if.vlb_addr);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({bus_if.vlb_req, bus_if.rsp_valid, bus_if.cmd_ready} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_abort: got req/rv/rdy=%b required 000",
               {bus_if.vlb_req, bus_if.rsp_valid, bus_if.cmd_ready});
    end
    rst = 1'b0;
    ack_never = 1'b0;
    step();
    step();
    checks++;
    if ({bus_if.rsp_valid, bus_if.cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_norsp: got rv/rdy=%b required 01", {bus_if.rsp_valid, bus_if.cmd_ready});
    end
    issue(1'b1, 32'h0000_000C, 32'h0000_0000);
    wait_rsp();
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_err} !== 2'b10 || bus_if.rsp_rdata !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL rstmid_next: got rv/err=%b rdata=%h required 10 a5a50001",
               {bus_if.rsp_valid, bus_if.rsp_err}, bus_if.rsp_rdata);
    end
    handshake();
  endtask

`ifdef VLB_REG_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    ack_never = 1'b1;
    issue(1'b1, 32'h0000_000C, 32'h0000_0000);
    while ((bus_if.vlb_req === 1'b1) && (n < 100)) begin
      n++;
      step();
    end
    ack_never = 1'b0;
    checks++;
    if (n != 16 || {bus_if.rsp_valid, bus_if.rsp_err} !== 2'b11 || bus_if.rsp_rdata !== 32'h0000_0000) begin
      errors++;
      $display("FAIL timeout_abort: got cycles=%0d rv/err=%b rdata=%h required 16 11 00000000",
               n, {bus_if.rsp_valid, bus_if.rsp_err}, bus_if.rsp_rdata);
    end
    handshake();
    ack_delay = 15;
    n = 0;
    issue(1'b1, 32'h0000_000C, 32'h0000_0000);
    while ((bus_if.vlb_req === 1'b1) && (n < 100)) begin
      n++;
      step();
    end
    ack_delay = 0;
    checks++;
    if (n != 16 || {bus_if.rsp_valid, bus_if.rsp_err} !== 2'b10 || bus_if.rsp_rdata !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL timeout_ack_wins: got cycles=%0d rv/err=%b rdata=%h required 16 10 a5a50001",
               n, {bus_if.rsp_valid, bus_if.rsp_err}, bus_if.rsp_rdata);
    end
    handshake();
  endtask
`endif

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_rnw   = 1'b0;
    bus_if.cmd_addr  = 32'h0000_0000;
    bus_if.cmd_wdata = 32'h0000_0000;
    bus_if.rsp_ready = 1'b0;
    test_reset();
    test_read_volatile();
    test_write_read();
    test_misaligned();
    test_stall();
    test_spurious_ack();
    test_back_to_back();
    test_reset_mid();
`ifdef VLB_REG_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
